// File: rtl/mest_pro_pkg.sv
// rtl/mest_pro_pkg.sv - shared widths, field positions and FSM states for the MESTPro fetch stage.
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 8
`endif
`ifndef OPERANDA_SIZE
`define OPERANDA_SIZE 8
`endif
`ifndef OPERANDB_SIZE
`define OPERANDB_SIZE 8
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 24
`endif

package mest_pro_pkg;

  localparam int DEF_OPCODE_W = `OPCODE_SIZE;
  localparam int DEF_OPA_W    = `OPERANDA_SIZE;
  localparam int DEF_OPB_W    = `OPERANDB_SIZE;
  localparam int DEF_INSTR_W  = `INSTRUCTION_SIZE;
  localparam int DEF_PC_W     = 8;
  localparam int DEF_RS_DEPTH = 4;

  // Word layout is {opcode, operand1, operand2}, MSB first.
  localparam int OPB_LSB    = 0;
  localparam int OPA_LSB    = DEF_OPB_W;
  localparam int OPCODE_LSB = DEF_OPA_W + DEF_OPB_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/mest_pro_ret_stack.sv
// rtl/mest_pro_ret_stack.sv - return-address LIFO; push onto full or pop from empty is dropped.
module mest_pro_ret_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign sp_dec   = sp - 1'b1;
  assign wr_idx   = IDX_W'(sp);
  assign rd_idx   = IDX_W'(sp_dec);
  assign full     = (sp == SP_W'(DEPTH));
  assign empty    = (sp == '0);
  assign top_data = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/mest_pro_fetch.sv
// rtl/mest_pro_fetch.sv - fetch/issue sequencer feeding the MESTPro execute stage.
module mest_pro_fetch
  import mest_pro_pkg::*;
#(
  parameter int OPCODE_W = DEF_OPCODE_W,
  parameter int OPA_W    = DEF_OPA_W,
  parameter int OPB_W    = DEF_OPB_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int PC_W     = DEF_PC_W,
  parameter int RS_DEPTH = DEF_RS_DEPTH
) (
  input  logic                clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  output logic                o_imem_rd,
  output logic [PC_W-1:0]     o_imem_addr,
  input  logic [INSTR_W-1:0]  i_imem_data,
  output logic [OPCODE_W-1:0] o_op_code,
  output logic [OPA_W-1:0]    o_operand1,
  output logic [OPB_W-1:0]    o_operand2,
  output logic [INSTR_W-1:0]  o_load_reg,
  output logic                o_execute,
  input  logic                i_exec_done,
  input  logic                i_jump,
  input  logic                i_return_pc,
  input  logic                i_end_of_code,
  output logic [PC_W-1:0]     o_pc,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_stack_err
);

  fetch_state_e state;

  logic [PC_W-1:0]        pc;
  logic [PC_W-1:0]        pc_inc;
  logic [PC_W-1:0]        jump_target;
  logic [OPA_W+OPB_W-1:0] target_full;
  logic [PC_W-1:0]        stk_top;
  logic                   stk_full;
  logic                   stk_empty;
  logic                   stk_push;
  logic                   stk_pop;
  logic                   stk_clear;
  logic                   done_now;
  logic                   stack_err;

  assign pc_inc      = pc + 1'b1;
  assign target_full = {o_operand1, o_operand2};
  assign jump_target = target_full[PC_W-1:0];

  // Stack commands follow the same halt > return > jump priority as the PC update.
  assign done_now  = (state == ST_WAIT) && i_exec_done;
  assign stk_pop   = done_now && !i_end_of_code && i_return_pc;
  assign stk_push  = done_now && !i_end_of_code && !i_return_pc && i_jump;
  assign stk_clear = (state == ST_HALTED) && i_start;

  mest_pro_ret_stack #(
    .DATA_W (PC_W),
    .DEPTH  (RS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset_n   (i_reset_n),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      pc         <= '0;
      stack_err  <= 1'b0;
      o_op_code  <= '0;
      o_operand1 <= '0;
      o_operand2 <= '0;
      o_load_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          state <= ST_LATCH;
        end
        ST_LATCH: begin
          o_op_code  <= i_imem_data[OPCODE_LSB +: OPCODE_W];
          o_operand1 <= i_imem_data[OPA_LSB +: OPA_W];
          o_operand2 <= i_imem_data[OPB_LSB +: OPB_W];
          o_load_reg <= i_imem_data;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_exec_done) begin
            if (i_end_of_code) begin
              state <= ST_HALTED;
            end else begin
              state <= ST_FETCH;
              if (i_return_pc) begin
                if (stk_empty) begin
                  stack_err <= 1'b1;
                  pc        <= pc_inc;
                end else begin
                  pc <= stk_top;
                end
              end else if (i_jump) begin
                if (stk_full) stack_err <= 1'b1;
                pc <= jump_target;
              end else begin
                pc <= pc_inc;
              end
            end
          end
        end
        ST_HALTED: begin
          if (i_start) begin
            pc        <= '0;
            stack_err <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_rd   = (state == ST_FETCH);
  assign o_imem_addr = pc;
  assign o_execute   = (state == ST_ISSUE);
  assign o_pc        = pc;
  assign o_busy      = (state == ST_FETCH) || (state == ST_LATCH) ||
                       (state == ST_ISSUE) || (state == ST_WAIT);
  assign o_halted    = (state == ST_HALTED);
  assign o_stack_err = stack_err;

endmodule

// File: tb/tb_mest_pro_fetch.sv
// tb/tb_mest_pro_fetch.sv - scoreboard bench for mest_pro_fetch with an executing-program reference model.
module tb_mest_pro_fetch;

  localparam logic [7:0] OP_JMP  = 8'h01;
  localparam logic [7:0] OP_RET  = 8'h02;
  localparam logic [7:0] OP_JH   = 8'h03;
  localparam logic [7:0] OP_HALT = 8'hFF;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic        o_imem_rd;
  logic [7:0]  o_imem_addr;
  logic [23:0] i_imem_data = '0;
  logic [7:0]  o_op_code, o_operand1, o_operand2;
  logic [23:0] o_load_reg;
  logic        o_execute;
  logic        i_exec_done = 1'b0;
  logic        i_jump = 1'b0, i_return_pc = 1'b0, i_end_of_code = 1'b0;
  logic [7:0]  o_pc;
  logic        o_busy, o_halted, o_stack_err;

  always #5 clk = ~clk;

  mest_pro_fetch dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start),
    .o_imem_rd(o_imem_rd), .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data),
    .o_op_code(o_op_code), .o_operand1(o_operand1), .o_operand2(o_operand2),
    .o_load_reg(o_load_reg), .o_execute(o_execute), .i_exec_done(i_exec_done),
    .i_jump(i_jump), .i_return_pc(i_return_pc), .i_end_of_code(i_end_of_code),
    .o_pc(o_pc), .o_busy(o_busy), .o_halted(o_halted), .o_stack_err(o_stack_err)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [23:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  // Program-level model: current PC, return addresses as a queue, sticky error.
  logic [7:0]  m_pc = '0;
  logic [7:0]  m_stack[$];
  logic [23:0] m_word = '0;
  bit          m_err = 0;
  bit          m_halted = 0;
  bit          hold = 0;
  bit          pend = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (o_imem_rd) i_imem_data <= mem[o_imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_issue(input int at_cyc);
    exp_t e;
    e.pc   = m_pc;
    e.word = mem[m_pc];
    e.cyc  = at_cyc;
    m_word = e.word;
    exp_q.push_back(e);
  endtask

  task automatic model_done(input logic [23:0] w, output bit j, output bit r, output bit h);
    logic [7:0] op;
    logic [7:0] nxt;
    op  = w[23:16];
    nxt = m_pc + 8'd1;
    j = (op == OP_JMP) || (op == OP_JH);
    r = (op == OP_RET);
    h = (op == OP_HALT) || (op == OP_JH);
    if (h) begin
      m_halted = 1;
    end else begin
      if (r) begin
        if (m_stack.size() == 0) begin
          m_err = 1;
          m_pc  = nxt;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (j) begin
        if (m_stack.size() == 4) m_err = 1;
        else m_stack.push_back(nxt);
        m_pc = w[7:0];
      end else begin
        m_pc = nxt;
      end
      expect_issue(cyc + 3);
    end
  endtask

  // Exec responder and monitor: one cycle after each issue, return exec-done with the flags
  // the model derives from the instruction; flags are random noise whenever done is low.
  always @(negedge clk) begin : resp
    bit   j, r, h;
    exp_t e;
    i_exec_done   = 1'b0;
    i_jump        = 1'($urandom);
    i_return_pc   = 1'($urandom);
    i_end_of_code = 1'($urandom);
    if (hold) begin
      pend = 0;
    end else begin
      if (pend) begin
        model_done(m_word, j, r, h);
        if (r) j = j | 1'($urandom);
        i_exec_done   = 1'b1;
        i_jump        = j;
        i_return_pc   = r;
        i_end_of_code = h;
        pend = 0;
      end
      if (o_execute) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_execute: issue at pc %0h, none expected", o_pc);
        end else begin
          e = exp_q.pop_front();
          check("issue_pc", 32'(o_pc), 32'(e.pc));
          check("issue_opcode", 32'(o_op_code), 32'(e.word[23:16]));
          check("issue_operand1", 32'(o_operand1), 32'(e.word[15:8]));
          check("issue_operand2", 32'(o_operand2), 32'(e.word[7:0]));
          check("issue_load_reg", 32'(o_load_reg), 32'(e.word));
          check("issue_cycle", 32'(cyc), 32'(e.cyc));
          pend = 1;
        end
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_stack.delete();
    m_pc = '0;
    m_err = 0;
    m_halted = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_rd", 32'(o_imem_rd), 0);
    check("rst_imem_addr", 32'(o_imem_addr), 0);
    check("rst_op_code", 32'(o_op_code), 0);
    check("rst_operand1", 32'(o_operand1), 0);
    check("rst_operand2", 32'(o_operand2), 0);
    check("rst_load_reg", 32'(o_load_reg), 0);
    check("rst_execute", 32'(o_execute), 0);
    check("rst_pc", 32'(o_pc), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_halted", 32'(o_halted), 0);
    check("rst_stack_err", 32'(o_stack_err), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    if (m_halted) begin
      m_pc = '0;
      m_stack.delete();
      m_err = 0;
    end
    m_halted = 0;
    i_start = 1'b1;
    expect_issue(cyc + 3);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Called at a negedge; reset is sampled one edge later.
  task automatic abort_run();
    hold = 1;
    @(negedge clk);
    i_reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    i_reset_n = 1'b1;
    hold = 0;
  endtask

  task automatic wait_exec(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_execute && n < 50);
    if (!o_execute) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no execute within %0d cycles", name, n);
    end
  endtask

  task automatic wait_halt(input string name, input logic [7:0] exp_pc, input bit exp_err);
    int n = 0;
    while (!m_halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!m_halted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: model not halted after %0d cycles", name, n);
    end
    repeat (2) @(negedge clk);
    check({name, "_halted"}, 32'(o_halted), 1);
    check({name, "_busy"}, 32'(o_busy), 0);
    check({name, "_pc"}, 32'(o_pc), 32'(exp_pc));
    check({name, "_stack_err"}, 32'(o_stack_err), 32'(exp_err));
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) mem[i] = {8'h20, 8'(i), 8'(i + 1)};
  endtask

  initial begin
    fill_plain();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    i_reset_n = 1'b1;
    model_reset();

    // Linear ADD, SUB, HALT; a start pulse while busy must be ignored.
    mem[0] = {8'h10, 8'h01, 8'h02};
    mem[1] = {8'h11, 8'h03, 8'h04};
    mem[2] = {OP_HALT, 8'h00, 8'h00};
    do_start();
    wait_exec("linear_first");
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    wait_halt("linear", 8'd2, 1'b0);

    // JMP to 0x10 at PC 5, RET back to 6, HALT there.
    fill_plain();
    mem[5]    = {OP_JMP, 8'h00, 8'h10};
    mem[8'h10] = {OP_RET, 8'h00, 8'h00};
    mem[6]    = {OP_HALT, 8'h00, 8'h00};
    do_start();
    wait_halt("jmp_ret", 8'd6, 1'b0);

    // Five nested JMPs overflow the 4-deep stack, then unwind to an underflowing RET.
    fill_plain();
    mem[0]     = {OP_JMP, 8'h00, 8'h20};
    mem[8'h20] = {OP_JMP, 8'h00, 8'h30};
    mem[8'h30] = {OP_JMP, 8'h00, 8'h40};
    mem[8'h40] = {OP_JMP, 8'h00, 8'h50};
    mem[8'h50] = {OP_JMP, 8'h00, 8'h60};
    mem[8'h60] = {OP_RET, 8'h00, 8'h00};
    mem[8'h41] = {OP_RET, 8'h00, 8'h00};
    mem[8'h31] = {OP_RET, 8'h00, 8'h00};
    mem[8'h21] = {OP_RET, 8'h00, 8'h00};
    mem[1]     = {OP_RET, 8'h00, 8'h00};
    mem[2]     = {OP_HALT, 8'h00, 8'h00};
    do_start();
    wait_halt("nested", 8'd2, 1'b1);

    // Jump and halt together: halt wins, PC stays; restart clears the sticky error.
    fill_plain();
    mem[0] = {OP_JH, 8'h00, 8'h80};
    do_start();
    wait_halt("jump_halt", 8'd0, 1'b0);

    // PC wrap: jump to 0xFF, plain instruction there, fetch continues at 0.
    fill_plain();
    mem[0]     = {OP_JMP, 8'h00, 8'hFF};
    mem[8'hFF] = {8'h33, 8'h44, 8'h55};
    do_start();
    wait_exec("wrap_first");
    mem[0] = {OP_HALT, 8'h00, 8'h00};
    wait_halt("wrap", 8'd0, 1'b0);

    // Reset while waiting for exec-done; nothing issues until the next start.
    fill_plain();
    do_start();
    wait_exec("abort_first");
    abort_run();
    repeat (20) @(negedge clk);
    check("abort_idle_busy", 32'(o_busy), 0);
    mem[1] = {OP_HALT, 8'h00, 8'h00};
    do_start();
    wait_halt("after_abort", 8'd1, 1'b0);

    // Random programs, each cut short by reset.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 55)      mem[i] = {8'($urandom_range(16, 254)), 16'($urandom)};
        else if (r < 75) mem[i] = {OP_JMP, 16'($urandom)};
        else if (r < 93) mem[i] = {OP_RET, 16'($urandom)};
        else if (r < 97) mem[i] = {OP_JH, 16'($urandom)};
        else             mem[i] = {OP_HALT, 16'($urandom)};
      end
      do_start();
      repeat (300) @(negedge clk);
      if (!m_halted) check("rand_stack_err", 32'(o_stack_err), 32'(m_err));
      abort_run();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
